// File: rtl/l1c_mem_arbiter.sv
// Round-robin arbiter sharing one memory port between the I-cache and D-cache.
// A grant is registered and held for a full read line fill or a single write beat.
module l1c_mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int TYPE_W     = 3,
  parameter int READ_BEATS = 4,
  parameter int CNT_W      = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              I_req,
  input  logic [ADDR_W-1:0] I_addr,
  input  logic [TYPE_W-1:0] I_type,
  output logic [DATA_W-1:0] I_out,
  output logic              I_wait,
  input  logic              D_req,
  input  logic [ADDR_W-1:0] D_addr,
  input  logic              D_write,
  input  logic [DATA_W-1:0] D_in,
  input  logic [TYPE_W-1:0] D_type,
  output logic [DATA_W-1:0] D_out,
  output logic              D_wait,
  output logic              M_req,
  output logic [ADDR_W-1:0] M_addr,
  output logic              M_write,
  output logic [DATA_W-1:0] M_in,
  output logic [TYPE_W-1:0] M_type,
  input  logic [DATA_W-1:0] M_out,
  input  logic              M_wait
);

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;

  typedef struct packed {
    logic              req;
    logic [ADDR_W-1:0] addr;
    logic              write;
    logic [DATA_W-1:0] data;
    logic [TYPE_W-1:0] kind;
  } mem_req_t;

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(READ_BEATS - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             last, last_nxt;  // 0: I-cache served last, 1: D-cache
  mem_req_t         own;
  logic             beat, done;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      last  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      last  <= last_nxt;
    end
  end

  // Read data is broadcast; only the current owner treats it as valid.
  assign I_out = M_out;
  assign D_out = M_out;

  always_comb begin
    own       = '0;
    state_nxt = state;
    cnt_nxt   = cnt;
    last_nxt  = last;
    I_wait    = I_req;
    D_wait    = D_req;
    beat      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (I_req && D_req) state_nxt = last ? GNT_I : GNT_D;
        else if (I_req)     state_nxt = GNT_I;
        else if (D_req)     state_nxt = GNT_D;
      end
      GNT_I: begin
        own    = '{req: I_req, addr: I_addr, write: 1'b0, data: '0, kind: I_type};
        I_wait = M_wait;
        beat   = I_req & ~M_wait;
        done   = ~I_req | (beat & (cnt == LAST_BEAT));
      end
      GNT_D: begin
        own    = '{req: D_req, addr: D_addr, write: D_write, data: D_in, kind: D_type};
        D_wait = M_wait;
        beat   = D_req & ~M_wait;
        done   = ~D_req | (beat & (D_write | (cnt == LAST_BEAT)));
      end
      default: state_nxt = IDLE;
    endcase
    if (done) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
      last_nxt  = (state == GNT_D);
    end else if (beat) begin
      cnt_nxt = cnt + CNT_W'(1);
    end
    M_req   = own.req;
    M_addr  = own.addr;
    M_write = own.write;
    M_in    = own.data;
    M_type  = own.kind;
  end

endmodule

// File: tb/tb_l1c_mem_arbiter.sv
// Cycle-table bench for l1c_mem_arbiter: each row gives inputs and the expected owner,
// from which the memory-side and wait outputs are predicted.
module tb_l1c_mem_arbiter;

  localparam logic [2:0] ITYPE = 3'd1;
  localparam logic [2:0] DTYPE = 3'd2;

  logic        clk = 1'b0;
  logic        rst;
  logic        I_req, D_req, D_write, M_wait;
  logic [31:0] I_addr, D_addr, D_in, M_out;
  logic [2:0]  I_type, D_type;
  logic [31:0] I_out, D_out, M_addr, M_in;
  logic        I_wait, D_wait, M_req, M_write;
  logic [2:0]  M_type;

  always #5 clk = ~clk;

  l1c_mem_arbiter dut (
    .clk(clk), .rst(rst),
    .I_req(I_req), .I_addr(I_addr), .I_type(I_type), .I_out(I_out), .I_wait(I_wait),
    .D_req(D_req), .D_addr(D_addr), .D_write(D_write), .D_in(D_in), .D_type(D_type),
    .D_out(D_out), .D_wait(D_wait),
    .M_req(M_req), .M_addr(M_addr), .M_write(M_write), .M_in(M_in), .M_type(M_type),
    .M_out(M_out), .M_wait(M_wait)
  );

  typedef struct {
    bit          rst;
    bit          ireq;
    logic [31:0] iaddr;
    bit          dreq;
    bit          dwr;
    logic [31:0] daddr;
    logic [31:0] din;
    bit          mwait;
    logic [31:0] mout;
    int          own;   // 0 idle, 1 I-cache granted, 2 D-cache granted
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(bit r, bit ir, logic [31:0] ia, bit dr, bit dw,
                              logic [31:0] da, logic [31:0] di, bit mw, int own);
    vec_t v;
    v.rst = r; v.ireq = ir; v.iaddr = ia; v.dreq = dr; v.dwr = dw;
    v.daddr = da; v.din = di; v.mwait = mw; v.mout = 32'h0; v.own = own;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp, int idx);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  initial begin
    vec_t v, e;
    logic [31:0] x_addr, x_in;
    logic        x_req, x_wr, x_iw, x_dw;
    logic [2:0]  x_type;

    // reset with both requesting, then D wins the first tie and reads a line
    tbl.push_back(mk(1, 1, 32'h1000, 1, 0, 32'h2000, 32'h0, 0, 0));   // 0
    tbl.push_back(mk(0, 1, 32'h1000, 1, 0, 32'h2000, 32'h0, 0, 0));   // 1
    tbl.push_back(mk(0, 1, 32'h1000, 1, 0, 32'h2000, 32'h0, 0, 2));   // 2 beat
    tbl.push_back(mk(0, 1, 32'h1000, 1, 0, 32'h2004, 32'h0, 0, 2));   // 3 beat
    tbl.push_back(mk(0, 1, 32'h1000, 1, 0, 32'h2008, 32'h0, 1, 2));   // 4 stall
    tbl.push_back(mk(0, 1, 32'h1000, 1, 0, 32'h2008, 32'h0, 0, 2));   // 5 beat
    tbl.push_back(mk(0, 1, 32'h1000, 1, 0, 32'h200C, 32'h0, 0, 2));   // 6 last beat
    tbl.push_back(mk(0, 1, 32'h1000, 1, 0, 32'h3000, 32'h0, 0, 0));   // 7 turnaround
    tbl.push_back(mk(0, 1, 32'h1000, 1, 0, 32'h3000, 32'h0, 0, 1));   // 8 I line fill
    tbl.push_back(mk(0, 1, 32'h1004, 1, 0, 32'h3000, 32'h0, 0, 1));   // 9
    tbl.push_back(mk(0, 1, 32'h1008, 1, 0, 32'h3000, 32'h0, 0, 1));   // 10
    tbl.push_back(mk(0, 1, 32'h100C, 1, 0, 32'h3000, 32'h0, 0, 1));   // 11
    // D single-beat write while I keeps requesting
    tbl.push_back(mk(0, 1, 32'h1010, 1, 1, 32'h3000, 32'h1234_5678, 0, 0)); // 12
    tbl.push_back(mk(0, 1, 32'h1010, 1, 1, 32'h3000, 32'h1234_5678, 1, 2)); // 13
    tbl.push_back(mk(0, 1, 32'h1010, 1, 1, 32'h3000, 32'h1234_5678, 0, 2)); // 14
    tbl.push_back(mk(0, 1, 32'h1010, 1, 0, 32'h3004, 32'h0, 0, 0));   // 15
    // reset during beat 3 of an I fill
    tbl.push_back(mk(0, 1, 32'h1010, 1, 0, 32'h3004, 32'h0, 0, 1));   // 16
    tbl.push_back(mk(0, 1, 32'h1014, 1, 0, 32'h3004, 32'h0, 0, 1));   // 17
    tbl.push_back(mk(1, 1, 32'h1018, 1, 0, 32'h3004, 32'h0, 0, 1));   // 18
    tbl.push_back(mk(0, 1, 32'h1018, 1, 0, 32'h4000, 32'h0, 0, 0));   // 19
    // D aborts after 2 beats; pending I granted next and must get a full line
    tbl.push_back(mk(0, 1, 32'h1018, 1, 0, 32'h4000, 32'h0, 0, 2));   // 20
    tbl.push_back(mk(0, 1, 32'h1018, 1, 0, 32'h4004, 32'h0, 0, 2));   // 21
    tbl.push_back(mk(0, 1, 32'h1018, 0, 0, 32'h4008, 32'h0, 0, 2));   // 22 abort
    tbl.push_back(mk(0, 1, 32'h1000, 0, 0, 32'h0,    32'h0, 0, 0));   // 23
    tbl.push_back(mk(0, 1, 32'h1000, 0, 0, 32'h0,    32'h0, 1, 1));   // 24
    tbl.push_back(mk(0, 1, 32'h1000, 0, 0, 32'h0,    32'h0, 1, 1));   // 25
    tbl.push_back(mk(0, 1, 32'h1000, 0, 0, 32'h0,    32'h0, 0, 1));   // 26
    tbl.push_back(mk(0, 1, 32'h1004, 0, 0, 32'h0,    32'h0, 0, 1));   // 27
    tbl.push_back(mk(0, 1, 32'h1008, 0, 0, 32'h0,    32'h0, 0, 1));   // 28
    tbl.push_back(mk(0, 1, 32'h100C, 0, 0, 32'h0,    32'h0, 0, 1));   // 29
    tbl.push_back(mk(0, 0, 32'h0,    0, 0, 32'h0,    32'h0, 0, 0));   // 30 idle
    // D write with three wait cycles
    tbl.push_back(mk(0, 0, 32'h0, 1, 1, 32'h0001_0004, 32'hDEAD_BEEF, 0, 0)); // 31
    tbl.push_back(mk(0, 0, 32'h0, 1, 1, 32'h0001_0004, 32'hDEAD_BEEF, 1, 2)); // 32
    tbl.push_back(mk(0, 0, 32'h0, 1, 1, 32'h0001_0004, 32'hDEAD_BEEF, 1, 2)); // 33
    tbl.push_back(mk(0, 0, 32'h0, 1, 1, 32'h0001_0004, 32'hDEAD_BEEF, 1, 2)); // 34
    tbl.push_back(mk(0, 0, 32'h0, 1, 1, 32'h0001_0004, 32'hDEAD_BEEF, 0, 2)); // 35
    // lone D read: full line
    tbl.push_back(mk(0, 0, 32'h0, 1, 0, 32'h5000, 32'h0, 0, 0));      // 36
    tbl.push_back(mk(0, 0, 32'h0, 1, 0, 32'h5000, 32'h0, 0, 2));      // 37
    tbl.push_back(mk(0, 0, 32'h0, 1, 0, 32'h5004, 32'h0, 0, 2));      // 38
    tbl.push_back(mk(0, 0, 32'h0, 1, 0, 32'h5008, 32'h0, 0, 2));      // 39
    tbl.push_back(mk(0, 0, 32'h0, 1, 0, 32'h500C, 32'h0, 0, 2));      // 40
    tbl.push_back(mk(0, 0, 32'h0, 0, 0, 32'h0,    32'h0, 0, 0));      // 41

    rst = 1'b1; I_req = 0; D_req = 0; D_write = 0; M_wait = 0;
    I_addr = '0; D_addr = '0; D_in = '0; M_out = '0;
    I_type = ITYPE; D_type = DTYPE;
    @(posedge clk);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      v = tbl[i];
      v.mout = 32'hC0DE_0000 ^ 32'(i);
      rst = v.rst; I_req = v.ireq; I_addr = v.iaddr; D_req = v.dreq;
      D_write = v.dwr; D_addr = v.daddr; D_in = v.din; M_wait = v.mwait; M_out = v.mout;
      sb.push_back(v);
      #1;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL scoreboard row %0d: got empty queue expected entry", i);
        continue;
      end
      e = sb.pop_front();
      x_req = 0; x_addr = '0; x_wr = 0; x_in = '0; x_type = '0;
      x_iw = e.ireq; x_dw = e.dreq;
      if (e.own == 1) begin
        x_req = e.ireq; x_addr = e.iaddr; x_type = ITYPE; x_iw = e.mwait;
      end else if (e.own == 2) begin
        x_req = e.dreq; x_addr = e.daddr; x_wr = e.dwr; x_in = e.din;
        x_type = DTYPE; x_dw = e.mwait;
      end
      chk("M_req",   32'(M_req),   32'(x_req),  i);
      chk("M_addr",  M_addr,       x_addr,      i);
      chk("M_write", 32'(M_write), 32'(x_wr),   i);
      chk("M_in",    M_in,         x_in,        i);
      chk("M_type",  32'(M_type),  32'(x_type), i);
      chk("I_wait",  32'(I_wait),  32'(x_iw),   i);
      chk("D_wait",  32'(D_wait),  32'(x_dw),   i);
      chk("I_out",   I_out,        e.mout,      i);
      chk("D_out",   D_out,        e.mout,      i);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
